instr_packer: RTL and testbench

//  Writer side of the 16-bit instruction format consumed by the control decoder.
//  - Accepts decoded fields {opcode, rd, rs, rt} over a valid/ready stream.
//  - Packs each field set into word = {opcode[3:0], rd[3:0], rs[3:0], rt[3:0]}.
//  - Buffers words in a small FIFO, then writes them to instruction memory at consecutive addresses from base_addr.
//  - Sits between the program source (test loader or host link) and instruction memory.

---
 rtl/isa_pkg.sv | 45 ++++
 rtl/packer_fifo.sv | 54 +++++
 rtl/instr_packer.sv | 159 +++++++++++++++
 tb/tb_instr_packer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared definitions for the 16-bit instruction format.
//   - Opcode encodings used by the control decoder.
//   - Bit positions of each field inside an instruction word.
//   - State encoding of the instruction packer FSM.
//   - pack_fields(): assembles {opcode, rd, rs, rt} into one word.
package isa_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_LD  = 4'd7;
  localparam logic [3:0] OP_ST  = 4'd8;
  localparam logic [3:0] OP_BEQ = 4'd9;

  localparam int OPC_MSB = 15;
  localparam int RD_MSB  = 11;
  localparam int RS_MSB  = 7;
  localparam int RT_MSB  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pack_state_e;

  // Places each 4-bit field at its slot in the instruction word.
  function automatic logic [15:0] pack_fields(input logic [3:0] opcode,
                                              input logic [3:0] rd,
                                              input logic [3:0] rs,
                                              input logic [3:0] rt);
    logic [15:0] word;
    word = '0;
    word[OPC_MSB -: 4] = opcode;
    word[RD_MSB  -: 4] = rd;
    word[RS_MSB  -: 4] = rs;
    word[RT_MSB  -: 4] = rt;
    return word;
  endfunction

endpackage

// File: rtl/packer_fifo.sv
// Synchronous FIFO holding packed instruction words between the input
// stream and the instruction-memory write port.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (reset empties it)
//   push, wdata  write one entry (ignored when full)
//   pop          drop the head entry (ignored when empty)
//   rdata        current head entry
//   full, empty  flags derived from the registered pointers
module packer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers; reset discards any queued entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_packer.sv
// Instruction packer: accepts decoded field sets over a valid/ready stream,
// packs them into 16-bit words, buffers them in packer_fifo and writes them
// to instruction memory at consecutive addresses starting at base_addr.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start, base_addr               begin a program (honoured only in IDLE)
//   in_valid/in_ready              field-set handshake
//   in_opcode/in_rd/in_rs/in_rt    fields; in_last marks final instruction
//   mem_we/mem_addr/mem_wdata      write port, held until mem_ready
//   busy, done                     FSM status; done pulses for one cycle
//   count                          words written, saturating at 2^ADDR_W
//   wrap                           sticky, write address rolled over
// Optional feature (macro INSTR_PACKER_CHECK_EN): opcodes above MAX_OPCODE
// are stored as 16'h0000 and flagged on the sticky bad_op output.
module instr_packer
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
`ifdef INSTR_PACKER_CHECK_EN
  ,
  parameter int MAX_OPCODE = 9
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs,
  input  logic [3:0]        in_rt,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              wrap
`ifdef INSTR_PACKER_CHECK_EN
  ,
  output logic              bad_op
`endif
);

  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  pack_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wrap_q, wrap_d;
  logic              fifo_full, fifo_empty;
  logic [15:0]       fifo_rdata, fifo_wdata, packed_word;
  logic              push, pop;

  assign packed_word = pack_fields(in_opcode, in_rd, in_rs, in_rt);

`ifdef INSTR_PACKER_CHECK_EN
  logic opcode_bad;
  logic bad_op_q, bad_op_d;
  assign opcode_bad = int'(in_opcode) > MAX_OPCODE;
  assign fifo_wdata = opcode_bad ? 16'h0000 : packed_word;
  assign bad_op     = bad_op_q;
`else
  assign fifo_wdata = packed_word;
`endif

  // in_ready uses the registered full flag, so a full FIFO refuses a push
  // even when a pop happens in the same cycle.
  assign in_ready = (state_q == ST_LOAD) && !fifo_full;
  assign push     = in_valid && in_ready;
  assign mem_we   = !fifo_empty && ((state_q == ST_LOAD) || (state_q == ST_DRAIN));
  assign pop      = mem_we && mem_ready;

  // Data is forced to zero while no write is offered so idle outputs stay 0.
  assign mem_wdata = mem_we ? fifo_rdata : 16'h0000;
  assign mem_addr  = addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign count     = count_q;
  assign wrap      = wrap_q;

  packer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state logic: FSM sequencing plus address, count and sticky flags.
  // start is only looked at in IDLE; elsewhere it has no effect.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wrap_d  = wrap_q;
`ifdef INSTR_PACKER_CHECK_EN
    bad_op_d = bad_op_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = base_addr;
          count_d = '0;
          wrap_d  = 1'b0;
`ifdef INSTR_PACKER_CHECK_EN
          bad_op_d = 1'b0;
`endif
        end
      end
      ST_LOAD:  if (push && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (pop) begin
      addr_d = addr_q + ADDR_W'(1);
      if (addr_q == {ADDR_W{1'b1}}) wrap_d = 1'b1;
      if (count_q != COUNT_MAX) count_d = count_q + (ADDR_W+1)'(1);
    end
`ifdef INSTR_PACKER_CHECK_EN
    if (push && opcode_bad) bad_op_d = 1'b1;
`endif
  end

  // State registers; reset returns to IDLE with every status output cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
`ifdef INSTR_PACKER_CHECK_EN
      bad_op_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
`ifdef INSTR_PACKER_CHECK_EN
      bad_op_q <= bad_op_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// Self-checking bench for instr_packer: table-driven programs plus
// hand-written sequences for back-pressure, reset and ignored start.
module tb_instr_packer;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int NVEC   = 7;

  logic              clk = 1'b0;
  logic              rstN;
  logic              start;
  logic [ADDR_W-1:0] baseAddr;
  logic              inValid;
  logic              inReady;
  logic [3:0]        inOpcode, inRd, inRs, inRt;
  logic              inLast;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [15:0]       memWdata;
  logic              memReady;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              wrap;
`ifdef INSTR_PACKER_CHECK_EN
  logic              badOp;
`endif

  instr_packer #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .start     (start),
    .base_addr (baseAddr),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_opcode (inOpcode),
    .in_rd     (inRd),
    .in_rs     (inRs),
    .in_rt     (inRt),
    .in_last   (inLast),
    .mem_we    (memWe),
    .mem_addr  (memAddr),
    .mem_wdata (memWdata),
    .mem_ready (memReady),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .wrap      (wrap)
`ifdef INSTR_PACKER_CHECK_EN
    ,
    .bad_op    (badOp)
`endif
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  base;
    logic [3:0]  op, rd, rs, rt;
    logic        last;
    logic [15:0] expWord;
    logic [7:0]  expAddr;
  } vec_t;

  wr_t  wrLog[$];
  vec_t vecs[NVEC];
  int   checks   = 0;
  int   failures = 0;
  logic [15:0] stallWords[5] = '{16'h2111, 16'h3222, 16'h4333, 16'h5444, 16'h6555};

  // Memory-side monitor: records every accepted write, sampled mid-cycle
  // so the values are settled before the handshake edge.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rstN && memWe && memReady) begin
      e.addr = memAddr;
      e.data = memWdata;
      wrLog.push_back(e);
    end
  end

  // Hard time limit so the bench always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // All tasks start and end one time unit after a rising edge.
  task automatic startProgram(input logic [7:0] base);
    start    = 1'b1;
    baseAddr = base;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Offers one field set and waits (bounded) until it is accepted.
  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] rd,
                               input logic [3:0] rs, input logic [3:0] rt,
                               input logic last);
    bit ok;
    ok = 1'b0;
    inOpcode = op; inRd = rd; inRs = rs; inRt = rt; inLast = last;
    inValid  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (inReady) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    inLast  = 1'b0;
    if (!ok) checkOutput("push_accept_timeout", 32'd0, 32'd1);
  endtask

  // Waits for the done pulse and checks the end-of-program status.
  task automatic waitDone(input int expCount, input logic expWrap);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      checkOutput("count_at_done", 32'(count), 32'(expCount));
      checkOutput("wrap_at_done", 32'(wrap), 32'(expWrap));
      checkOutput("busy_in_done", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("idle_after_done", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_mem_we"}, 32'(memWe), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(memAddr), 32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(memWdata), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_count"}, 32'(count), 32'd0);
    checkOutput({tag, "_wrap"}, 32'(wrap), 32'd0);
    checkOutput({tag, "_in_ready"}, 32'(inReady), 32'd0);
`ifdef INSTR_PACKER_CHECK_EN
    checkOutput({tag, "_bad_op"}, 32'(badOp), 32'd0);
`endif
  endtask

  initial begin : main
    int progStart;
    int n;
    logic expWrap;
    logic expBad;

    // Programs: two words at 0x10, one word at 0x80, wrap at 0xFF,
    // then an out-of-range opcode.
    vecs[0] = '{8'h10, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 16'h0123, 8'h10};
    vecs[1] = '{8'h10, 4'h1, 4'h4, 4'h5, 4'h6, 1'b1, 16'h1456, 8'h11};
    vecs[2] = '{8'h80, 4'h3, 4'hF, 4'hF, 4'hF, 1'b1, 16'h3FFF, 8'h80};
    vecs[3] = '{8'hFF, 4'h7, 4'h1, 4'h0, 4'h0, 1'b0, 16'h7100, 8'hFF};
    vecs[4] = '{8'hFF, 4'h8, 4'h2, 4'h0, 4'h0, 1'b0, 16'h8200, 8'h00};
    vecs[5] = '{8'hFF, 4'h9, 4'h3, 4'h0, 4'h0, 1'b1, 16'h9300, 8'h01};
`ifdef INSTR_PACKER_CHECK_EN
    vecs[6] = '{8'h50, 4'hE, 4'h1, 4'h2, 4'h3, 1'b1, 16'h0000, 8'h50};
`else
    vecs[6] = '{8'h50, 4'hE, 4'h1, 4'h2, 4'h3, 1'b1, 16'hE123, 8'h50};
`endif

    rstN = 1'b0; start = 1'b0; baseAddr = '0; inValid = 1'b0;
    inOpcode = '0; inRd = '0; inRs = '0; inRt = '0; inLast = 1'b0;
    memReady = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checkIdleOutputs("reset");
    rstN = 1'b1;
    @(posedge clk); #1;

    // Table-driven programs with an always-ready memory.
    progStart = 0;
    for (int i = 0; i < NVEC; i++) begin
      if (i == progStart) begin
        wrLog.delete();
        startProgram(vecs[i].base);
      end
      applyStimulus(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].last);
      if (vecs[i].last) begin
        n = i - progStart + 1;
        expWrap = (int'(vecs[progStart].base) + n) > 256;
        waitDone(n, expWrap);
        checkOutput($sformatf("log_len_v%0d", i), 32'(wrLog.size()), 32'(n));
        for (int j = 0; j < n; j++) begin
          if (j < wrLog.size()) begin
            checkOutput($sformatf("addr_v%0d", progStart + j),
                        32'(wrLog[j].addr), 32'(vecs[progStart + j].expAddr));
            checkOutput($sformatf("data_v%0d", progStart + j),
                        32'(wrLog[j].data), 32'(vecs[progStart + j].expWord));
          end
        end
`ifdef INSTR_PACKER_CHECK_EN
        expBad = 1'b0;
        for (int j = progStart; j <= i; j++) if (vecs[j].op > 4'd9) expBad = 1'b1;
        checkOutput($sformatf("bad_op_v%0d", i), 32'(badOp), 32'(expBad));
`else
        expBad = 1'b0;
`endif
        progStart = i + 1;
      end
    end

    // Back-pressure: memory stalls while the FIFO fills to DEPTH entries.
    wrLog.delete();
    memReady = 1'b0;
    startProgram(8'h20);
    for (int k = 0; k < DEPTH; k++)
      applyStimulus(4'(k + 2), 4'(k + 1), 4'(k + 1), 4'(k + 1), 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_in_ready_%0d", k), 32'(inReady), 32'd0);
      checkOutput($sformatf("stall_mem_we_%0d", k), 32'(memWe), 32'd1);
      checkOutput($sformatf("stall_addr_%0d", k), 32'(memAddr), 32'h20);
      checkOutput($sformatf("stall_data_%0d", k), 32'(memWdata), 32'h2111);
    end
    @(posedge clk); #1;
    memReady = 1'b1;
    applyStimulus(4'h6, 4'h5, 4'h5, 4'h5, 1'b1);
    waitDone(5, 1'b0);
    checkOutput("stall_log_len", 32'(wrLog.size()), 32'd5);
    for (int j = 0; j < 5; j++) begin
      if (j < wrLog.size()) begin
        checkOutput($sformatf("stall_log_addr_%0d", j), 32'(wrLog[j].addr), 32'(8'h20 + j));
        checkOutput($sformatf("stall_log_data_%0d", j), 32'(wrLog[j].data), 32'(stallWords[j]));
      end
    end

    // Reset mid-program with three words queued behind a stalled memory.
    wrLog.delete();
    memReady = 1'b0;
    startProgram(8'h30);
    applyStimulus(4'h1, 4'h1, 4'h1, 4'h1, 1'b0);
    applyStimulus(4'h2, 4'h2, 4'h2, 4'h2, 1'b0);
    applyStimulus(4'h3, 4'h3, 4'h3, 4'h3, 1'b0);
    rstN = 1'b0;
    #1;
    checkIdleOutputs("midreset");
    @(posedge clk); #1;
    rstN = 1'b1;
    memReady = 1'b1;
    @(posedge clk); #1;
    startProgram(8'h40);
    applyStimulus(4'h4, 4'hA, 4'hB, 4'hC, 1'b1);
    waitDone(1, 1'b0);
    checkOutput("after_reset_log_len", 32'(wrLog.size()), 32'd1);
    if (wrLog.size() > 0) begin
      checkOutput("after_reset_addr", 32'(wrLog[0].addr), 32'h40);
      checkOutput("after_reset_data", 32'(wrLog[0].data), 32'h4ABC);
    end

    // start pulsed during LOAD must not move the base address.
    wrLog.delete();
    startProgram(8'h60);
    applyStimulus(4'h2, 4'h3, 4'h4, 4'h5, 1'b0);
    startProgram(8'h99);
    checkOutput("busy_after_ignored_start", 32'(busy), 32'd1);
    applyStimulus(4'h3, 4'h4, 4'h5, 4'h6, 1'b1);
    waitDone(2, 1'b0);
    checkOutput("ignored_start_log_len", 32'(wrLog.size()), 32'd2);
    if (wrLog.size() > 1) begin
      checkOutput("ignored_start_addr0", 32'(wrLog[0].addr), 32'h60);
      checkOutput("ignored_start_data0", 32'(wrLog[0].data), 32'h2345);
      checkOutput("ignored_start_addr1", 32'(wrLog[1].addr), 32'h61);
      checkOutput("ignored_start_data1", 32'(wrLog[1].data), 32'h3456);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
